johnson_decoder: RTL and testbench

- Receives an externally generated W-bit Johnson (twisted-ring) code, e.g. the LED-bank counter stepped by pb[19], and decodes it back to a binary state index.
- The code is sampled through a synchroniser on hz100.
- Tracks step direction, keeps a signed up/down position count, and flags illegal codes and skipped states.
- Sits between the Johnson-counter outputs and the display/debug logic in top.

---
 rtl/johnson_decoder_if.sv | 46 ++++
 rtl/johnson_decoder.sv | 170 +++++++++++++++++
 tb/tb_johnson_decoder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if
//   Groups the Johnson decoder's code input, clear strobe and decoded
//   outputs into one bundle. Clock (hz100) and reset stay plain ports on
//   the decoder.
//
//   Parameters: W  Johnson code width
//               IW decoded index width
//               CW position counter width
//
//   Signals:
//     jc_in        W   Johnson code from the source counter (async to hz100)
//     clr          1   synchronous clear of pos_count and err_illegal
//     idx          IW  decoded state index, 0..2W-1
//     valid        1   idx holds a legally decoded state
//     step_up      1   one-cycle pulse, index advanced by +1
//     step_dn      1   one-cycle pulse, index moved by -1
//     err_skip     1   one-cycle pulse, legal code jumped 2..2W-2 states
//     err_illegal  1   sticky, a non-Johnson code was sampled
//     pos_count    CW  two's-complement net step count (wraps)
//
//   Modports: master drives jc_in/clr (source side), slave is the decoder.
interface johnson_decoder_if #(
  parameter int W  = 8,
  parameter int IW = 4,
  parameter int CW = 8
);
  logic [W-1:0]         jc_in;
  logic                 clr;
  logic [IW-1:0]        idx;
  logic                 valid;
  logic                 step_up;
  logic                 step_dn;
  logic                 err_skip;
  logic                 err_illegal;
  logic signed [CW-1:0] pos_count;

  modport master (
    output jc_in, clr,
    input  idx, valid, step_up, step_dn, err_skip, err_illegal, pos_count
  );

  modport slave (
    input  jc_in, clr,
    output idx, valid, step_up, step_dn, err_skip, err_illegal, pos_count
  );
endinterface

// File: rtl/johnson_decoder.sv
// johnson_decoder
//   Decodes an externally generated W-bit Johnson (twisted-ring) code back
//   to a binary state index. The code is brought into the hz100 domain by a
//   two-flop synchroniser, checked for legality, and compared with the last
//   decoded index to produce step-direction pulses, a signed net position
//   count, a skip-error pulse and a sticky illegal-code flag.
//
//   Ports:
//     hz100   in   system clock, rising edge
//     reset   in   asynchronous active-low reset
//     bus     johnson_decoder_if.slave (jc_in, clr in; idx, valid,
//             step_up, step_dn, err_skip, err_illegal, pos_count out)
//
//   Optional build macro: JOHNSON_DEC_GLITCH_FILTER_EN
//     When defined, the synchronised code must be identical on two
//     consecutive samples before it is decoded (one extra cycle latency,
//     rejects single-cycle glitches from bouncing sources).
module johnson_decoder #(
  parameter int W  = 8,
  parameter int IW = 4,
  parameter int CW = 8
) (
  input  logic               hz100,
  input  logic               reset,
  johnson_decoder_if.slave   bus
);

  localparam int SEQ_LEN = 2 * W;
  localparam logic signed [CW-1:0] CNT_ONE = CW'(1);

  // A Johnson code has at most one boundary between a run of 0s and 1s.
  function automatic logic code_legal_f(input logic [W-1:0] c);
    int edges;
    edges = 0;
    for (int i = 0; i < W - 1; i++) begin
      if (c[i] != c[i+1]) edges++;
    end
    return (edges <= 1);
  endfunction

  // Filling phase (MSB clear) counts ones upward; draining phase (MSB set)
  // counts down from 2W.
  function automatic logic [IW-1:0] code_index_f(input logic [W-1:0] c);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) begin
      if (c[i]) ones++;
    end
    return c[W-1] ? IW'(SEQ_LEN - ones) : IW'(ones);
  endfunction

  // Forward distance from 'from' to 'to' around the 2W-state ring.
  function automatic int ring_diff_f(input logic [IW-1:0] to_idx,
                                     input logic [IW-1:0] from_idx);
    int d;
    d = int'(to_idx) - int'(from_idx);
    if (d < 0) d += SEQ_LEN;
    return d;
  endfunction

  logic [W-1:0]         sync_p0;
  logic [W-1:0]         s_p1;
  logic                 vld_p0;
  logic                 vld_p1;
  logic [IW-1:0]        idx_p2;
  logic                 vld_p2;
  logic                 step_up_p2;
  logic                 step_dn_p2;
  logic                 err_skip_p2;
  logic                 err_illegal_p2;
  logic signed [CW-1:0] pos_count_p2;

  logic                 eval_en;
  logic                 code_legal;
  logic [IW-1:0]        code_idx;
  int                   step_diff;

  // ---- stage 0/1: synchroniser; vld marks data that really came through it
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      s_p1    <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= bus.jc_in;
      s_p1    <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

`ifdef JOHNSON_DEC_GLITCH_FILTER_EN
  logic [W-1:0] s_hist_p2;
  logic         vld_hist_p2;

  // ---- stage 2 (filter): previous synchronised sample for stability check
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      s_hist_p2   <= '0;
      vld_hist_p2 <= 1'b0;
    end else begin
      s_hist_p2   <= s_p1;
      vld_hist_p2 <= vld_p1;
    end
  end

  assign eval_en = vld_p1 & vld_hist_p2 & (s_p1 == s_hist_p2);
`else
  assign eval_en = vld_p1;
`endif

  always_comb begin
    code_legal = code_legal_f(s_p1);
    code_idx   = code_index_f(s_p1);
    step_diff  = ring_diff_f(code_idx, idx_p2);
  end

  // ---- stage 2: decode, step classification, counting and flags
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      idx_p2         <= '0;
      vld_p2         <= 1'b0;
      step_up_p2     <= 1'b0;
      step_dn_p2     <= 1'b0;
      err_skip_p2    <= 1'b0;
      err_illegal_p2 <= 1'b0;
      pos_count_p2   <= '0;
    end else begin
      step_up_p2  <= 1'b0;
      step_dn_p2  <= 1'b0;
      err_skip_p2 <= 1'b0;
      if (bus.clr) begin
        pos_count_p2   <= '0;
        err_illegal_p2 <= 1'b0;
      end
      if (eval_en) begin
        if (!code_legal) begin
          // Later assignment wins over a same-cycle clr.
          vld_p2         <= 1'b0;
          err_illegal_p2 <= 1'b1;
        end else begin
          idx_p2 <= code_idx;
          vld_p2 <= 1'b1;
          // A first legal sample after reset/illegal only reloads idx.
          if (vld_p2) begin
            if (step_diff == 1) begin
              step_up_p2 <= 1'b1;
              if (!bus.clr) pos_count_p2 <= pos_count_p2 + CNT_ONE;
            end else if (step_diff == SEQ_LEN - 1) begin
              step_dn_p2 <= 1'b1;
              if (!bus.clr) pos_count_p2 <= pos_count_p2 - CNT_ONE;
            end else if (step_diff != 0) begin
              err_skip_p2 <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.idx         = idx_p2;
  assign bus.valid       = vld_p2;
  assign bus.step_up     = step_up_p2;
  assign bus.step_dn     = step_dn_p2;
  assign bus.err_skip    = err_skip_p2;
  assign bus.err_illegal = err_illegal_p2;
  assign bus.pos_count   = pos_count_p2;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder
//   Scoreboard bench for johnson_decoder. Each applied code runs through a
//   behavioural model built on a table of the 2W Johnson states; the
//   expected output set is queued when the code is driven and compared when
//   the decoder's latency has elapsed.
module tb_johnson_decoder;
  localparam int W  = 8;
  localparam int IW = 4;
  localparam int CW = 8;
`ifdef JOHNSON_DEC_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    logic [16:0] v;
    string       name;
  } exp_t;

  logic hz100 = 1'b0;
  logic reset = 1'b0;

  johnson_decoder_if #(.W(W), .IW(IW), .CW(CW)) bus ();

  johnson_decoder #(.W(W), .IW(IW), .CW(CW)) dut (
    .hz100 (hz100),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 hz100 = ~hz100;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]     seq [0:2*W-1];
  logic [IW-1:0]    m_idx;
  logic             m_valid;
  logic             m_ill;
  logic signed [7:0] m_pos;
  exp_t             sb [$];

  wire [16:0] obs = {bus.idx, bus.valid, bus.step_up, bus.step_dn,
                     bus.err_skip, bus.err_illegal, bus.pos_count};

  function automatic int find_state(input logic [W-1:0] c);
    for (int k = 0; k < 2*W; k++) begin
      if (seq[k] == c) return k;
    end
    return -1;
  endfunction

  task automatic model_push(input logic [W-1:0] code, input bit with_clr,
                            input string name);
    int   k;
    int   d;
    logic up, dn, sk;
    exp_t e;
    k  = find_state(code);
    up = 1'b0; dn = 1'b0; sk = 1'b0;
    if (with_clr) m_pos = 8'sd0;
    if (k < 0) begin
      m_valid = 1'b0;
      m_ill   = 1'b1;
    end else begin
      if (with_clr) m_ill = 1'b0;
      if (m_valid) begin
        d = (k - int'(m_idx) + 2*W) % (2*W);
        if (d == 1) begin
          up = 1'b1;
          if (!with_clr) m_pos = m_pos + 8'sd1;
        end else if (d == 2*W - 1) begin
          dn = 1'b1;
          if (!with_clr) m_pos = m_pos - 8'sd1;
        end else if (d != 0) begin
          sk = 1'b1;
        end
      end
      m_idx   = k[IW-1:0];
      m_valid = 1'b1;
    end
    e.v    = {m_idx, m_valid, up, dn, sk, m_ill, m_pos};
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic apply_code(input logic [W-1:0] code, input bit with_clr,
                            input string name);
    exp_t        e;
    logic [IW-1:0] prev_idx;
    prev_idx = m_idx;
    model_push(code, with_clr, name);
    @(negedge hz100);
    bus.jc_in = code;
    repeat (LAT - 1) @(posedge hz100);
    #1;
    checks++;
    if ({bus.idx, bus.step_up, bus.step_dn, bus.err_skip} !== {prev_idx, 3'b000}) begin
      errors++;
      $display("FAIL %s_early idx/up/dn/skip got %h want %h", name,
               {bus.idx, bus.step_up, bus.step_dn, bus.err_skip}, {prev_idx, 3'b000});
    end
    @(negedge hz100);
    bus.clr = with_clr;
    @(posedge hz100);
    #1;
    bus.clr = 1'b0;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s outputs got %h want %h", e.name, obs, e.v);
    end
    @(posedge hz100);
    #1;
    checks++;
    if ({bus.step_up, bus.step_dn, bus.err_skip} !== 3'b000) begin
      errors++;
      $display("FAIL %s_pulse_len up/dn/skip got %b want 000", name,
               {bus.step_up, bus.step_dn, bus.err_skip});
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bus.jc_in = '0;
    bus.clr   = 1'b0;
    reset     = 1'b0;
    m_idx = '0; m_valid = 1'b0; m_ill = 1'b0; m_pos = 8'sd0;
    repeat (3) @(posedge hz100);
    #1;
    checks++;
    if (obs !== 17'h0) begin
      errors++;
      $display("FAIL reset_state outputs got %h want %h", obs, 17'h0);
    end
    model_push(8'b00000000, 1'b0, "reset_first_legal");
    @(negedge hz100);
    reset = 1'b1;
    repeat (LAT - 1) @(posedge hz100);
    #1;
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_early got %b want 0", bus.valid);
    end
    @(posedge hz100);
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s outputs got %h want %h", e.name, obs, e.v);
    end
  endtask

  task automatic test_up_steps();
    apply_code(8'b00000001, 1'b0, "up_1");
    apply_code(8'b00000011, 1'b0, "up_2");
    apply_code(8'b00000111, 1'b0, "up_3");
  endtask

`ifdef JOHNSON_DEC_GLITCH_FILTER_EN
  task automatic test_glitch();
    apply_code(8'b00000011, 1'b0, "glitch_pre_dn");
    @(negedge hz100);
    bus.jc_in = 8'b01010000;
    @(negedge hz100);
    bus.jc_in = 8'b00000011;
    repeat (8) begin
      @(posedge hz100);
      #1;
      checks++;
      if ({bus.err_illegal, bus.step_up, bus.step_dn, bus.err_skip, bus.valid, bus.idx}
          !== {4'b0000, 1'b1, m_idx}) begin
        errors++;
        $display("FAIL glitch_hold got %h want %h",
                 {bus.err_illegal, bus.step_up, bus.step_dn, bus.err_skip, bus.valid, bus.idx},
                 {4'b0000, 1'b1, m_idx});
      end
    end
    apply_code(8'b00000111, 1'b0, "glitch_post_up");
  endtask
`endif

  task automatic test_wrap();
    apply_code(8'b00000011, 1'b0, "back_2");
    apply_code(8'b00000001, 1'b0, "back_1");
    apply_code(8'b00000000, 1'b0, "back_0");
    apply_code(8'b10000000, 1'b0, "wrap_dn_15");
    apply_code(8'b00000000, 1'b0, "wrap_up_0");
  endtask

  task automatic test_skip_illegal();
    apply_code(8'b00000001, 1'b0, "climb_1");
    apply_code(8'b00000011, 1'b0, "climb_2");
    apply_code(8'b00000111, 1'b0, "climb_3");
    apply_code(8'b00111111, 1'b0, "skip_6");
    apply_code(8'b01010000, 1'b0, "illegal");
    apply_code(8'b01111111, 1'b0, "reload_7");
  endtask

  task automatic test_clr();
    @(negedge hz100);
    bus.clr = 1'b1;
    m_pos = 8'sd0;
    m_ill = 1'b0;
    @(posedge hz100);
    #1;
    bus.clr = 1'b0;
    checks++;
    if ({bus.err_illegal, bus.pos_count} !== {m_ill, m_pos}) begin
      errors++;
      $display("FAIL clr ill/pos got %h want %h", {bus.err_illegal, bus.pos_count}, {m_ill, m_pos});
    end
  endtask

  task automatic test_clr_vs_illegal();
    apply_code(8'b01010000, 1'b1, "illegal_with_clr");
    apply_code(8'b01111111, 1'b0, "reload_after_clr");
    test_clr();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 130; n++) begin
      apply_code(seq[m_idx + 4'd1], 1'b0, "run_up");
    end
    checks++;
    if (bus.pos_count !== 8'h82) begin
      errors++;
      $display("FAIL pos_wrap got %h want 82", bus.pos_count);
    end
    apply_code(seq[m_idx + 4'd1], 1'b1, "step_with_clr");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge hz100);
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 17'h0) begin
      errors++;
      $display("FAIL reset_mid_clear outputs got %h want %h", obs, 17'h0);
    end
    bus.jc_in = seq[5];
    m_idx = '0; m_valid = 1'b0; m_ill = 1'b0; m_pos = 8'sd0;
    model_push(seq[5], 1'b0, "reset_mid_reload");
    @(negedge hz100);
    reset = 1'b1;
    repeat (LAT - 1) @(posedge hz100);
    #1;
    checks++;
    if ({bus.valid, bus.idx} !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_mid_early valid/idx got %h want 00", {bus.valid, bus.idx});
    end
    @(posedge hz100);
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s outputs got %h want %h", e.name, obs, e.v);
    end
  endtask

  initial begin
    seq[0] = '0;
    for (int k = 1; k < 2*W; k++) begin
      seq[k] = {seq[k-1][W-2:0], ~seq[k-1][W-1]};
    end
    test_reset();
    test_up_steps();
`ifdef JOHNSON_DEC_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_wrap();
    test_skip_illegal();
    test_clr();
    test_clr_vs_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
